// File: rtl/cnu_serial.sv
// cnu_serial: serial min-sum check node unit, D q messages in, D r messages plus syndrome out.
module cnu_serial #(
  parameter int data_w = 8,
  parameter int D = 5,
  parameter int OFFSET = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [data_w-1:0]   in_q,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [data_w*D-1:0] r,
  output logic                syn
);
  localparam int MW = data_w - 1;
  localparam int IW = D > 1 ? $clog2(D) : 1;
  localparam logic [MW-1:0] MAXMAG = '1;
  localparam logic [MW-1:0] OFF = MW'(OFFSET);
  localparam logic [IW-1:0] LAST = IW'(D - 1);
  typedef enum logic {ACC, HOLD} state_t;
  state_t state_q;
  logic [IW-1:0] cnt_q, idx_q, h_idx_q, idx_d, s_idx;
  logic [MW-1:0] min1_q, min2_q, h_min1_q, h_min2_q, min1_d, min2_d, s_min1, s_min2, mag, m, mo;
  logic [D-1:0] sgn_q, h_sgn_q, sgn_d, s_sgn;
  logic par_q, h_par_q, par_d, s_par;
  logic [data_w-1:0] neg;
  logic [data_w*D-1:0] r_d;
  logic accept, xfer, last, direct, load, lt1, lt2;
  assign in_ready = state_q == ACC;
  assign accept = in_valid & in_ready;
  assign xfer = out_valid & out_ready;
  assign last = accept & (cnt_q == LAST);
  assign direct = ~out_valid | xfer;
  assign load = (state_q == ACC) ? last & direct : xfer;
  // -2^(data_w-1) negates to itself; its MSB flags the saturation case
  assign neg = -in_q;
  assign mag = in_q[data_w-1] ? (neg[data_w-1] ? MAXMAG : neg[MW-1:0]) : in_q[MW-1:0];
  assign lt1 = mag < min1_q;
  assign lt2 = mag < min2_q;
  assign min1_d = lt1 ? mag : min1_q;
  assign min2_d = lt1 ? min1_q : (lt2 ? mag : min2_q);
  assign idx_d = lt1 ? cnt_q : idx_q;
  assign par_d = par_q ^ in_q[data_w-1];
  always_comb begin
    sgn_d = sgn_q;
    sgn_d[cnt_q] = in_q[data_w-1];
  end
  assign s_min1 = (state_q == HOLD) ? h_min1_q : min1_d;
  assign s_min2 = (state_q == HOLD) ? h_min2_q : min2_d;
  assign s_idx = (state_q == HOLD) ? h_idx_q : idx_d;
  assign s_sgn = (state_q == HOLD) ? h_sgn_q : sgn_d;
  assign s_par = (state_q == HOLD) ? h_par_q : par_d;
  always_comb begin
    r_d = '0;
    m = '0;
    mo = '0;
    for (int k = 0; k < D; k++) begin
      m = (IW'(k) == s_idx) ? s_min2 : s_min1;
      mo = (m > OFF) ? m - OFF : '0;
      r_d[k*data_w +: data_w] = (s_par ^ s_sgn[k]) ? -{1'b0, mo} : {1'b0, mo};
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACC;
      cnt_q <= '0;
      min1_q <= MAXMAG;
      min2_q <= MAXMAG;
      idx_q <= '0;
      sgn_q <= '0;
      par_q <= 1'b0;
      h_min1_q <= MAXMAG;
      h_min2_q <= MAXMAG;
      h_idx_q <= '0;
      h_sgn_q <= '0;
      h_par_q <= 1'b0;
      out_valid <= 1'b0;
      r <= '0;
      syn <= 1'b0;
    end else begin
      if (accept) begin
        if (last) begin
          cnt_q <= '0;
          min1_q <= MAXMAG;
          min2_q <= MAXMAG;
          idx_q <= '0;
          sgn_q <= '0;
          par_q <= 1'b0;
          if (!direct) begin
            h_min1_q <= min1_d;
            h_min2_q <= min2_d;
            h_idx_q <= idx_d;
            h_sgn_q <= sgn_d;
            h_par_q <= par_d;
            state_q <= HOLD;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
          min1_q <= min1_d;
          min2_q <= min2_d;
          idx_q <= idx_d;
          sgn_q <= sgn_d;
          par_q <= par_d;
        end
      end
      if (state_q == HOLD && xfer) state_q <= ACC;
      if (load) begin
        r <= r_d;
        syn <= s_par;
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cnu_serial.sv
// tb_cnu_serial: random and directed checks of two cnu_serial instances (OFFSET 0 and 1) fed the same stream.
module tb_cnu_serial;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_q = '0;
  logic in_ready0, out_valid0, syn0, in_ready1, out_valid1, syn1;
  logic [39:0] r0, r1;
  int vectors = 0, errors = 0;
  logic [39:0] sb[$];

  cnu_serial #(.data_w(8), .D(5), .OFFSET(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_q(in_q),
    .out_valid(out_valid0), .out_ready(out_ready), .r(r0), .syn(syn0));
  cnu_serial #(.data_w(8), .D(5), .OFFSET(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_q(in_q),
    .out_valid(out_valid1), .out_ready(out_ready), .r(r1), .syn(syn1));

  always #5 clk = ~clk;

  // Each edge gets the smallest magnitude among the OTHER edges and the XOR of their signs
  function automatic logic [39:0] ref_r(input logic [39:0] qs, input int off);
    int mg[5];
    int v, m, sg;
    logic [39:0] res;
    res = '0;
    for (int j = 0; j < 5; j++) begin
      v = int'($signed(qs[j*8 +: 8]));
      mg[j] = v < 0 ? -v : v;
      if (mg[j] > 127) mg[j] = 127;
    end
    for (int k = 0; k < 5; k++) begin
      m = 127;
      sg = 0;
      for (int j = 0; j < 5; j++)
        if (j != k) begin
          if (mg[j] < m) m = mg[j];
          sg = sg ^ int'(qs[j*8+7]);
        end
      m = m > off ? m - off : 0;
      res[k*8 +: 8] = sg != 0 ? 8'(-m) : 8'(m);
    end
    return res;
  endfunction

  function automatic logic ref_syn(input logic [39:0] qs);
    return qs[7] ^ qs[15] ^ qs[23] ^ qs[31] ^ qs[39];
  endfunction

  function automatic logic [81:0] ref_all(input logic [39:0] qs);
    return {ref_syn(qs), ref_r(qs, 0), ref_syn(qs), ref_r(qs, 1)};
  endfunction

  function automatic logic [7:0] rand_q();
    int s;
    s = int'($urandom_range(3));
    if (s == 0) return 8'($urandom);
    if (s == 1) return 8'($urandom_range(8) - 4);
    if (s == 2) return 8'h80;
    return 8'h81;
  endfunction

  function automatic logic [39:0] rand_check();
    return {rand_q(), rand_q(), rand_q(), rand_q(), rand_q()};
  endfunction

  task automatic beat(input logic [7:0] q);
    @(negedge clk);
    in_valid = 1'b1;
    in_q = q;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic feed(input logic [39:0] qs, input int n);
    for (int k = 0; k < n; k++) beat(qs[k*8 +: 8]);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({out_valid0, in_ready0, syn0, r0, out_valid1, in_ready1, syn1, r1} !== {3'b010, 40'h0, 3'b010, 40'h0}) begin
      errors++;
      $display("FAIL reset: got v/rdy/syn %b%b%b r0=%h r1=%h, want 010 r=0", out_valid0, in_ready0, syn0, r0, r1);
    end
    rst = 1'b1;
  endtask

  task automatic test_directed(input string name, input logic [39:0] qs, input logic [39:0] e0, input logic [39:0] e1, input logic es);
    out_ready = 1'b1;
    feed(qs, 5);
    idle();
    vectors++;
    if ({out_valid0, out_valid1} !== 2'b11) begin
      errors++;
      $display("FAIL %s latency: out_valid=%b%b, want 11", name, out_valid0, out_valid1);
    end
    vectors++;
    if ({syn0, r0, syn1, r1} !== {es, e0, es, e1}) begin
      errors++;
      $display("FAIL %s literal: got syn=%b r0=%h r1=%h, want syn=%b r0=%h r1=%h", name, syn0, r0, r1, es, e0, e1);
    end
    vectors++;
    if ({syn0, r0, syn1, r1} !== ref_all(qs)) begin
      errors++;
      $display("FAIL %s model: got %h, want %h", name, {syn0, r0, syn1, r1}, ref_all(qs));
    end
    idle();
    vectors++;
    if ({out_valid0, out_valid1} !== 2'b00) begin
      errors++;
      $display("FAIL %s drop: out_valid=%b%b, want 00", name, out_valid0, out_valid1);
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] a, b;
    a = rand_check();
    b = rand_check();
    out_ready = 1'b0;
    feed(a, 5);
    feed(b, 5);
    idle();
    vectors++;
    if ({in_ready0, out_valid0, in_ready1, out_valid1} !== 4'b0101 || {syn0, r0, syn1, r1} !== ref_all(a)) begin
      errors++;
      $display("FAIL hold_entry: rdy/v=%b%b r0=%h, want 01 r0=%h", in_ready0, out_valid0, r0, ref_r(a, 0));
    end
    repeat (3) idle();
    vectors++;
    if ({in_ready0, out_valid0} !== 2'b01 || {syn0, r0, syn1, r1} !== ref_all(a)) begin
      errors++;
      $display("FAIL hold_stable: rdy/v=%b%b r0=%h, want 01 r0=%h", in_ready0, out_valid0, r0, ref_r(a, 0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if ({in_ready0, out_valid0, in_ready1, out_valid1} !== 4'b1111 || {syn0, r0, syn1, r1} !== ref_all(b)) begin
      errors++;
      $display("FAIL hold_release: rdy/v=%b%b r0=%h, want 11 r0=%h", in_ready0, out_valid0, r0, ref_r(b, 0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if ({out_valid0, out_valid1} !== 2'b00) begin
      errors++;
      $display("FAIL hold_drain: out_valid=%b%b, want 00", out_valid0, out_valid1);
    end
    a = rand_check();
    b = rand_check();
    feed(a, 5);
    feed(b, 4);
    @(negedge clk);
    in_valid = 1'b1;
    in_q = b[39:32];
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if ({in_ready0, out_valid0, in_ready1, out_valid1} !== 4'b1111 || {syn0, r0, syn1, r1} !== ref_all(b)) begin
      errors++;
      $display("FAIL bypass: rdy/v=%b%b r0=%h, want 11 r0=%h", in_ready0, out_valid0, r0, ref_r(b, 0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [39:0] x, y;
    x = rand_check();
    y = rand_check();
    out_ready = 1'b0;
    feed(x, 5);
    feed(40'hFFFFFFFFFF, 3);
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid0 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: out_valid=%b, want 1", out_valid0);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({out_valid0, in_ready0, out_valid1, in_ready1} !== 4'b0101) begin
      errors++;
      $display("FAIL async_reset: v/rdy=%b%b, want 01", out_valid0, in_ready0);
    end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    feed(y, 5);
    idle();
    vectors++;
    if ({out_valid0, out_valid1} !== 2'b11 || {syn0, r0, syn1, r1} !== ref_all(y)) begin
      errors++;
      $display("FAIL post_reset: v=%b r0=%h, want 1 r0=%h", out_valid0, r0, ref_r(y, 0));
    end
    idle();
  endtask

  task automatic test_random();
    logic [39:0] cur, exp;
    logic [81:0] prev;
    int nb;
    logic held;
    nb = 0;
    held = 1'b0;
    cur = '0;
    prev = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (held) begin
        vectors++;
        if ({syn0, r0, syn1, r1} !== prev) begin
          errors++;
          $display("FAIL stable cycle %0d: got %h, want %h", c, {syn0, r0, syn1, r1}, prev);
        end
      end
      in_valid = $urandom_range(3) != 0;
      in_q = rand_q();
      out_ready = $urandom_range(1) != 0;
      if (out_valid0 && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious cycle %0d: out_valid with no expected result", c);
        end else begin
          exp = sb.pop_front();
          if ({syn0, r0, syn1, r1} !== ref_all(exp) || out_valid1 !== 1'b1) begin
            errors++;
            $display("FAIL rand_result cycle %0d: got %h, want %h", c, {syn0, r0, syn1, r1}, ref_all(exp));
          end
        end
      end
      if (in_valid && in_ready0) begin
        cur[nb*8 +: 8] = in_q;
        nb++;
        if (nb == 5) begin
          sb.push_back(cur);
          nb = 0;
        end
      end
      held = out_valid0 && !out_ready;
      prev = {syn0, r0, syn1, r1};
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid0) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL drain_spurious: out_valid with no expected result");
        end else begin
          exp = sb.pop_front();
          if ({syn0, r0, syn1, r1} !== ref_all(exp)) begin
            errors++;
            $display("FAIL drain_result: got %h, want %h", {syn0, r0, syn1, r1}, ref_all(exp));
          end
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (sb.size() != 0 || out_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: %0d results outstanding, out_valid=%b, want 0 and 0", sb.size(), out_valid0);
    end
  endtask

  initial begin
    test_reset();
    test_directed("basic", {8'hFB, 8'd20, 8'd7, 8'hFD, 8'd10}, 40'hFD0303FB03, 40'hFE0202FC02, 1'b0);
    test_directed("saturation", {8'd2, 8'd1, 8'd1, 8'd1, 8'h80}, 40'hFFFFFFFF01, 40'h0000000000, 1'b1);
    test_directed("tie", {8'd4, 8'd4, 8'd4, 8'd4, 8'd4}, 40'h0404040404, 40'h0303030303, 1'b0);
    test_backpressure();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
